// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-port (I/D) round-robin arbiter in front of a single cache controller
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              i_rd_i,
  input  logic [ADDR_W-1:0] i_addr_i,
  input  logic              d_rd_i,
  input  logic              d_wr_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_data_in_i,
  input  logic              c_done_i,
  input  logic              c_hit_i,
  input  logic              c_err_i,
  input  logic [DATA_W-1:0] c_data_out_i,
  output logic              c_rd_o,
  output logic              c_wr_o,
  output logic [ADDR_W-1:0] c_addr_o,
  output logic [DATA_W-1:0] c_data_in_o,
  output logic              i_done_o,
  output logic              d_done_o,
  output logic              i_hit_o,
  output logic              d_hit_o,
  output logic              i_stall_o,
  output logic              d_stall_o,
  output logic [DATA_W-1:0] i_data_out_o,
  output logic [DATA_W-1:0] d_data_out_o,
  output logic              d_err_o,
  output logic              err_o,
  output logic              last_grant_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_I  = 2'd1,
    BUSY_D  = 2'd2,
    ILLEGAL = 2'd3
  } state_t;

  state_t              state_q;
  logic                req_rd_q;
  logic                req_wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   data_q;
  logic                last_grant_q;
  logic                err_q;

  logic                d_req;
  logic                d_illegal;
  logic                grant_d;

  assign d_req     = d_rd_i | d_wr_i;
  assign d_illegal = d_rd_i & d_wr_i;
  // D wins when it is the only requester, or on a tie when I was served last.
  assign grant_d   = d_req & (~i_rd_i | ~last_grant_q);

  // Arbitration FSM: latches the winning request and holds it until the cache completes.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      req_rd_q     <= 1'b0;
      req_wr_q     <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      last_grant_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (d_illegal) begin
            // Illegal D request is reported before any arbitration; I stays pending.
            state_q <= ILLEGAL;
          end else if (grant_d) begin
            state_q      <= BUSY_D;
            req_rd_q     <= d_rd_i;
            req_wr_q     <= d_wr_i;
            addr_q       <= d_addr_i;
            data_q       <= d_data_in_i;
            last_grant_q <= 1'b1;
          end else if (i_rd_i) begin
            state_q      <= BUSY_I;
            req_rd_q     <= 1'b1;
            req_wr_q     <= 1'b0;
            addr_q       <= i_addr_i;
            last_grant_q <= 1'b0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (c_err_i) begin
            err_q <= 1'b1;
          end
          if (c_done_i) begin
            state_q  <= IDLE;
            req_rd_q <= 1'b0;
            req_wr_q <= 1'b0;
          end
        end
        ILLEGAL: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Request type registers are only set while busy; gating with c_done keeps the
  // controller from seeing a fresh request in its own done cycle.
  assign c_rd_o      = req_rd_q & ~c_done_i;
  assign c_wr_o      = req_wr_q & ~c_done_i;
  assign c_addr_o    = addr_q;
  assign c_data_in_o = data_q;

  assign i_done_o  = (state_q == BUSY_I) & c_done_i;
  assign d_done_o  = ((state_q == BUSY_D) & c_done_i) | (state_q == ILLEGAL);
  assign d_err_o   = (state_q == ILLEGAL);

  assign i_hit_o   = c_hit_i & i_done_o;
  assign d_hit_o   = c_hit_i & d_done_o;

  assign i_stall_o = i_rd_i & ~i_done_o;
  assign d_stall_o = d_req & ~d_done_o;

  // Read data is broadcast; each consumer qualifies it with its own done.
  assign i_data_out_o = c_data_out_i;
  assign d_data_out_o = c_data_out_i;

  assign err_o        = err_q;
  assign last_grant_o = last_grant_q;

endmodule

// File: tb/tb_cache_arbiter.sv
// tb/tb_cache_arbiter.sv - self-checking bench for cache_arbiter
module tb_cache_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_rd = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic          d_rd = 1'b0;
  logic          d_wr = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [DW-1:0] d_data = '0;
  logic          c_done = 1'b0;
  logic          c_hit = 1'b0;
  logic          c_err = 1'b0;
  logic [DW-1:0] c_data = '0;

  logic          c_rd, c_wr;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_data_in;
  logic          i_done, d_done, i_hit, d_hit, i_stall, d_stall;
  logic [DW-1:0] i_data_out, d_data_out;
  logic          d_err, err, last_grant;

  int n_vec  = 0;
  int n_fail = 0;

  cache_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk_i(clk), .rst_i(rst),
    .i_rd_i(i_rd), .i_addr_i(i_addr),
    .d_rd_i(d_rd), .d_wr_i(d_wr), .d_addr_i(d_addr), .d_data_in_i(d_data),
    .c_done_i(c_done), .c_hit_i(c_hit), .c_err_i(c_err), .c_data_out_i(c_data),
    .c_rd_o(c_rd), .c_wr_o(c_wr), .c_addr_o(c_addr), .c_data_in_o(c_data_in),
    .i_done_o(i_done), .d_done_o(d_done), .i_hit_o(i_hit), .d_hit_o(d_hit),
    .i_stall_o(i_stall), .d_stall_o(d_stall),
    .i_data_out_o(i_data_out), .d_data_out_o(d_data_out),
    .d_err_o(d_err), .err_o(err), .last_grant_o(last_grant)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // {c_rd,c_wr,i_done,d_done,i_hit,d_hit,i_stall,d_stall,d_err,last_grant}
  function automatic logic [9:0] ctl();
    return {c_rd, c_wr, i_done, d_done, i_hit, d_hit, i_stall, d_stall, d_err, last_grant};
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    i_rd = 0; d_rd = 0; d_wr = 0; c_done = 0; c_hit = 0; c_err = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // inputs {i_rd,d_rd,d_wr,c_done,c_hit}; expected ctl(); expected c_addr when accessing
  typedef struct {
    logic [4:0]  in;
    logic [9:0]  exp;
    logic [15:0] addr;
  } vec_t;

  vec_t tbl[18];

  // reference model state (owner: 0 none, 1 I, 2 D, 3 illegal report)
  int          m_owner;
  logic        m_lg, m_err, m_isrd;
  logic [15:0] m_addr, m_data;
  int          m_cnt, m_lat;

  initial begin
    logic got;
    int   idle_cnt;
    logic p_idone, p_ddone;
    logic busy_i, busy_d, ill;
    logic e_crd, e_cwr, e_idone, e_ddone;
    logic [10:0] e_ctl;
    int   r;

    // single I read, then D/I tie, then illegal D with pending I
    tbl[0]  = '{5'b10000, 10'b0000001000, 16'h0000};
    tbl[1]  = '{5'b10000, 10'b1000001000, 16'h0040};
    tbl[2]  = '{5'b10000, 10'b1000001000, 16'h0040};
    tbl[3]  = '{5'b10011, 10'b0010100000, 16'h0000};
    tbl[4]  = '{5'b00000, 10'b0000000000, 16'h0000};
    tbl[5]  = '{5'b10100, 10'b0000001100, 16'h0000};
    tbl[6]  = '{5'b10100, 10'b0100001101, 16'h0100};
    tbl[7]  = '{5'b10110, 10'b0001001001, 16'h0000};
    tbl[8]  = '{5'b10000, 10'b0000001001, 16'h0000};
    tbl[9]  = '{5'b10000, 10'b1000001000, 16'h0040};
    tbl[10] = '{5'b10011, 10'b0010100000, 16'h0000};
    tbl[11] = '{5'b00000, 10'b0000000000, 16'h0000};
    tbl[12] = '{5'b11100, 10'b0000001100, 16'h0000};
    tbl[13] = '{5'b11100, 10'b0001001010, 16'h0000};
    tbl[14] = '{5'b10000, 10'b0000001000, 16'h0000};
    tbl[15] = '{5'b10000, 10'b1000001000, 16'h0040};
    tbl[16] = '{5'b10010, 10'b0010000000, 16'h0000};
    tbl[17] = '{5'b00000, 10'b0000000000, 16'h0000};

    // reset state
    do_reset();
    @(negedge clk);
    chk("reset_ctl", {ctl(), err}, 11'b0);
    chk("reset_addr", c_addr, 16'h0000);
    chk("reset_wdata", c_data_in, 16'h0000);

    // table-driven sequence
    i_addr = 16'h0040; d_addr = 16'h0100; d_data = 16'hBEEF;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      {i_rd, d_rd, d_wr, c_done, c_hit} = tbl[i].in;
      c_data = 16'($urandom);
      @(negedge clk);
      chk($sformatf("tbl%0d_ctl", i), ctl(), tbl[i].exp);
      chk($sformatf("tbl%0d_rdata", i), {i_data_out, d_data_out}, {c_data, c_data});
      if (tbl[i].exp[9] || tbl[i].exp[8])
        chk($sformatf("tbl%0d_addr", i), c_addr, tbl[i].addr);
      if (tbl[i].exp[8])
        chk($sformatf("tbl%0d_wdata", i), c_data_in, 16'hBEEF);
    end

    // both ports request continuously: D,I,D,I,D,I with one idle cycle between
    do_reset();
    i_addr = 16'h0040; d_addr = 16'h0100;
    @(posedge clk);
    #1 i_rd = 1; d_rd = 1; d_wr = 0;
    for (int k = 0; k < 6; k++) begin
      got = 0;
      idle_cnt = 0;
      for (int w = 0; w < 8 && !got; w++) begin
        @(negedge clk);
        if (c_rd) got = 1;
        else begin
          idle_cnt++;
          @(posedge clk);
          #1;
        end
      end
      chk($sformatf("rr%0d_granted", k), got, 1'b1);
      chk($sformatf("rr%0d_gap", k), idle_cnt, 1);
      chk($sformatf("rr%0d_winner", k), last_grant, (k % 2 == 0));
      chk($sformatf("rr%0d_addr", k), c_addr, (k % 2 == 0) ? 16'h0100 : 16'h0040);
      @(posedge clk);
      #1 c_done = 1; c_hit = 1;
      @(negedge clk);
      chk($sformatf("rr%0d_done", k), {i_done, d_done}, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(posedge clk);
      #1 c_done = 0; c_hit = 0;
    end
    i_rd = 0; d_rd = 0;

    // D address/data change mid-access is ignored
    do_reset();
    @(posedge clk);
    #1 d_wr = 1; d_addr = 16'h0100; d_data = 16'hBEEF;
    @(posedge clk);
    #1 d_addr = 16'h0222; d_data = 16'h1111;
    @(negedge clk);
    chk("hold_cwr", c_wr, 1'b1);
    chk("hold_addr", c_addr, 16'h0100);
    chk("hold_wdata", c_data_in, 16'hBEEF);
    @(posedge clk);
    #1 c_done = 1;
    @(negedge clk);
    chk("hold_addr_done", c_addr, 16'h0100);
    chk("hold_done", {c_wr, d_done}, 2'b01);
    @(posedge clk);
    #1 c_done = 0; d_wr = 0;

    // asynchronous reset two cycles into a D write, with err already set
    do_reset();
    d_addr = 16'h0100;
    @(posedge clk);
    #1 d_wr = 1;
    @(posedge clk);
    #1 c_err = 1;
    @(posedge clk);
    #1 c_err = 0;
    @(negedge clk);
    chk("rst_pre_err", err, 1'b1);
    chk("rst_pre_cwr", c_wr, 1'b1);
    #1 rst = 1;
    #1;
    chk("rst_async", {c_wr, c_rd, d_done, last_grant, err}, 5'b0);
    @(posedge clk);
    #1 d_wr = 0; rst = 0;

    // randomized traffic against the reference model
    do_reset();
    m_owner = 0; m_lg = 0; m_err = 0; m_isrd = 0;
    m_addr = '0; m_data = '0; m_cnt = 0; m_lat = 1;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(posedge clk);
      p_idone = (m_owner == 1) && c_done;
      p_ddone = ((m_owner == 2) && c_done) || (m_owner == 3);
      if (m_owner == 0) begin
        if (d_rd && d_wr) m_owner = 3;
        else if ((d_rd || d_wr) && (!i_rd || !m_lg)) begin
          m_owner = 2; m_lg = 1; m_addr = d_addr; m_data = d_data; m_isrd = d_rd;
          m_cnt = 1; m_lat = 1 + int'($urandom % 4);
        end else if (i_rd) begin
          m_owner = 1; m_lg = 0; m_addr = i_addr; m_isrd = 1;
          m_cnt = 1; m_lat = 1 + int'($urandom % 4);
        end
      end else if (m_owner == 3) begin
        m_owner = 0;
      end else begin
        if (c_err) m_err = 1;
        if (c_done) m_owner = 0;
        else m_cnt++;
      end
      #1;
      if (i_rd && p_idone) i_rd = 0;
      else if (!i_rd && ($urandom % 3 == 0)) i_rd = 1;
      if ((d_rd || d_wr) && p_ddone) begin
        d_rd = 0; d_wr = 0;
      end else if (!(d_rd || d_wr) && ($urandom % 3 == 0)) begin
        r = int'($urandom % 8);
        if (r == 0) begin d_rd = 1; d_wr = 1; end
        else if (r < 4) d_rd = 1;
        else d_wr = 1;
      end
      i_addr = 16'($urandom);
      d_addr = 16'($urandom);
      d_data = 16'($urandom);
      c_done = ((m_owner == 1) || (m_owner == 2)) && (m_cnt >= m_lat);
      c_hit  = c_done && ($urandom % 2 == 1);
      c_err  = ($urandom % 16 == 0);
      c_data = 16'($urandom);
      @(negedge clk);
      busy_i  = (m_owner == 1);
      busy_d  = (m_owner == 2);
      ill     = (m_owner == 3);
      e_crd   = (busy_i || (busy_d && m_isrd)) && !c_done;
      e_cwr   = busy_d && !m_isrd && !c_done;
      e_idone = busy_i && c_done;
      e_ddone = (busy_d && c_done) || ill;
      e_ctl   = {e_crd, e_cwr, e_idone, e_ddone, c_hit && e_idone, c_hit && e_ddone,
                 i_rd && !e_idone, (d_rd || d_wr) && !e_ddone, ill, m_lg, m_err};
      chk($sformatf("rnd%0d_ctl", cyc), {ctl(), err}, e_ctl);
      chk($sformatf("rnd%0d_rdata", cyc), {i_data_out, d_data_out}, {c_data, c_data});
      if (busy_i || busy_d)
        chk($sformatf("rnd%0d_addr", cyc), c_addr, m_addr);
      if (busy_d && !m_isrd)
        chk($sformatf("rnd%0d_wdata", cyc), c_data_in, m_data);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
